// File: rtl/utils_pkg.sv
// utils_pkg: shared RV32I decode types, opcode constants and the decode function.
//   pc_t / instr_raw_t : 32-bit program counter and raw instruction word
//   op_class_t         : operation class handed to the execute stage
//   imm_fmt_t          : immediate encoding format
//   s_id_ex_t          : decode -> execute control entry
//   s_trap_info_t      : sticky first-trap record
//   decode_rv32i()     : raw instruction -> control entry plus illegal flag
package utils_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_raw_t;

  typedef enum logic [3:0] {
    OpLui,
    OpAuipc,
    OpJal,
    OpJalr,
    OpBranch,
    OpLoad,
    OpStore,
    OpImm,
    OpReg,
    OpFence,
    OpSystem
  } op_class_t;

  typedef enum logic [2:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ
  } imm_fmt_t;

  typedef struct packed {
    op_class_t   op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    pc_t         pc;
  } s_id_ex_t;

  typedef struct packed {
    pc_t  pc_addr;
    logic active;
  } s_trap_info_t;

  typedef struct packed {
    s_id_ex_t ctrl;
    logic     illegal;
  } s_dec_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ADDI x0, x0, 0
  localparam instr_raw_t NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] gen_imm(input instr_raw_t instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    unique case (fmt)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'h000};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

  // Raw field decode; register fields a format does not use are zeroed so the
  // execute stage never sees immediate bits masquerading as register indices.
  function automatic s_dec_t decode_core(input instr_raw_t instr, input pc_t pc,
                                         input logic support_fence);
    s_dec_t     res;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_fmt_t   fmt;

    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    fmt = ImmNone;

    res              = '0;
    res.ctrl.pc      = pc;
    res.ctrl.funct3  = f3;
    res.ctrl.rs1     = instr[19:15];
    res.ctrl.rs2     = instr[24:20];
    res.ctrl.rd      = instr[11:7];
    res.ctrl.rd_we   = 1'b1;

    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        res.ctrl.op     = (opc == OPC_LUI) ? OpLui : (opc == OPC_AUIPC) ? OpAuipc : OpJal;
        fmt             = (opc == OPC_JAL) ? ImmJ : ImmU;
        res.ctrl.funct3 = 3'b000;
        res.ctrl.rs1    = 5'd0;
        res.ctrl.rs2    = 5'd0;
      end
      OPC_JALR: begin
        res.ctrl.op  = OpJalr;
        fmt          = ImmI;
        res.ctrl.rs2 = 5'd0;
      end
      OPC_BRANCH: begin
        res.ctrl.op    = OpBranch;
        fmt            = ImmB;
        res.ctrl.rd    = 5'd0;
        res.ctrl.rd_we = 1'b0;
        res.illegal    = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        res.ctrl.op  = OpLoad;
        fmt          = ImmI;
        res.ctrl.rs2 = 5'd0;
        res.illegal  = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OPC_STORE: begin
        res.ctrl.op    = OpStore;
        fmt            = ImmS;
        res.ctrl.rd    = 5'd0;
        res.ctrl.rd_we = 1'b0;
        res.illegal    = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        res.ctrl.op  = OpImm;
        fmt          = ImmI;
        res.ctrl.rs2 = 5'd0;
        if (f3 == 3'd1) begin
          res.illegal = (f7 != 7'h00);
        end else if (f3 == 3'd5) begin
          res.illegal        = (f7 != 7'h00) && (f7 != 7'h20);
          res.ctrl.funct7_b5 = f7[5];
        end
      end
      OPC_OP: begin
        res.ctrl.op = OpReg;
        if (f7 == 7'h20) begin
          res.ctrl.funct7_b5 = 1'b1;
          res.illegal        = (f3 != 3'd0) && (f3 != 3'd5);
        end else begin
          res.illegal = (f7 != 7'h00);
        end
      end
      OPC_FENCE: begin
        // Single-issue in-order core: fences have nothing to order.
        res.ctrl.op     = OpFence;
        res.ctrl.funct3 = 3'b000;
        res.ctrl.rs1    = 5'd0;
        res.ctrl.rs2    = 5'd0;
        res.ctrl.rd     = 5'd0;
        res.ctrl.rd_we  = 1'b0;
        res.illegal     = ~support_fence;
      end
      OPC_SYSTEM: begin
        res.ctrl.op  = OpSystem;
        fmt          = ImmI;
        res.ctrl.rs2 = 5'd0;
        // funct3 == 0: ECALL/EBREAK/MRET, selected by funct12 in imm.
        if (f3 == 3'd0) res.ctrl.rd_we = 1'b0;
      end
      default: res.illegal = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) res.illegal = 1'b1;
    res.ctrl.imm = gen_imm(instr, fmt);
    if (res.ctrl.rd == 5'd0) res.ctrl.rd_we = 1'b0;
    return res;
  endfunction

  // Illegal instructions are replaced by the decoded NOP, keeping the flag.
  function automatic s_dec_t decode_rv32i(input instr_raw_t instr, input pc_t pc,
                                          input logic support_fence);
    s_dec_t res;
    res = decode_core(instr, pc, support_fence);
    if (res.illegal) begin
      res         = decode_core(NOP_INSTR, pc, support_fence);
      res.illegal = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/decode.sv
// decode: RV32I decode stage with a single output register.
//   clk, rst                 : clock, synchronous active-high reset
//   fetch_start_i/_addr_i    : core start (rising edge) and boot PC
//   jump_i/jump_addr_i       : jump request (rising edge) and target
//   fetch_valid_i/ready_o    : instruction handshake from fetch
//   fetch_instr_i            : raw instruction
//   id_valid_o/id_ready_i    : handshake to execute
//   id_ctrl_o                : decoded control entry
//   illegal_instr_o          : one-cycle pulse when an illegal instr enters the register
//   trap_info_o              : sticky first-trap record, cleared on flush
module decode
  import utils_pkg::*;
#(
  parameter int unsigned SUPPORT_FENCE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_start_i,
  input  pc_t          fetch_start_addr_i,
  input  logic         jump_i,
  input  pc_t          jump_addr_i,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  instr_raw_t   fetch_instr_i,
  output logic         id_valid_o,
  input  logic         id_ready_i,
  output s_id_ex_t     id_ctrl_o,
  output logic         illegal_instr_o,
  output s_trap_info_t trap_info_o
);

  logic         r_start;
  logic         r_jump;
  logic         r_id_valid;
  logic         r_illegal;
  pc_t          r_pc;
  s_id_ex_t     r_id_ctrl;
  s_trap_info_t r_trap;

  logic         w_start_trig;
  logic         w_jump_trig;
  logic         w_flush;
  logic         w_accept;
  logic         w_pop;
  s_dec_t       w_dec;

  // Same edge detection as fetch so both stages flush in the same cycle.
  assign w_start_trig = fetch_start_i & ~r_start;
  assign w_jump_trig  = jump_i & ~r_jump;
  assign w_flush      = w_start_trig | w_jump_trig;

  assign fetch_ready_o = ~rst & ~w_flush & (~r_id_valid | id_ready_i);
  assign w_accept      = fetch_valid_i & fetch_ready_o;
  assign w_pop         = r_id_valid & id_ready_i;

  assign w_dec = decode_rv32i(fetch_instr_i, r_pc, SUPPORT_FENCE != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start    <= 1'b0;
      r_jump     <= 1'b0;
      r_id_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_pc       <= '0;
      r_id_ctrl  <= '0;
      r_trap     <= '0;
    end else begin
      r_start   <= fetch_start_i;
      r_jump    <= jump_i;
      r_illegal <= w_accept & w_dec.illegal;

      if (w_start_trig) begin
        r_pc <= fetch_start_addr_i;
      end else if (w_jump_trig) begin
        r_pc <= jump_addr_i & 32'hFFFF_FFFC;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_flush) begin
        r_id_valid <= 1'b0;
      end else if (w_accept) begin
        r_id_valid <= 1'b1;
        r_id_ctrl  <= w_dec.ctrl;
      end else if (w_pop) begin
        r_id_valid <= 1'b0;
      end

      // Only the first trap since the last flush is recorded.
      if (w_flush) begin
        r_trap <= '0;
      end else if (w_accept && w_dec.illegal && !r_trap.active) begin
        r_trap.pc_addr <= r_pc;
        r_trap.active  <= 1'b1;
      end
    end
  end

  assign id_valid_o      = r_id_valid;
  assign id_ctrl_o       = r_id_ctrl;
  assign illegal_instr_o = r_illegal;
  assign trap_info_o     = r_trap;

endmodule

// File: tb/tb_decode.sv
module tb_decode;
  import utils_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_start_i;
  pc_t          fetch_start_addr_i;
  logic         jump_i;
  pc_t          jump_addr_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  instr_raw_t   fetch_instr_i;
  logic         id_valid_o;
  logic         id_ready_i;
  s_id_ex_t     id_ctrl_o;
  logic         illegal_instr_o;
  s_trap_info_t trap_info_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode #(.SUPPORT_FENCE(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_start_i     (fetch_start_i),
    .fetch_start_addr_i(fetch_start_addr_i),
    .jump_i            (jump_i),
    .jump_addr_i       (jump_addr_i),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_ready_o     (fetch_ready_o),
    .fetch_instr_i     (fetch_instr_i),
    .id_valid_o        (id_valid_o),
    .id_ready_i        (id_ready_i),
    .id_ctrl_o         (id_ctrl_o),
    .illegal_instr_o   (illegal_instr_o),
    .trap_info_o       (trap_info_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic s_id_ex_t mk(input op_class_t op, input logic [2:0] f3, input logic f7b5,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic we,
                                  input logic [31:0] imm, input pc_t pc);
    s_id_ex_t c;
    c.op        = op;
    c.funct3    = f3;
    c.funct7_b5 = f7b5;
    c.rs1       = rs1;
    c.rs2       = rs2;
    c.rd        = rd;
    c.rd_we     = we;
    c.imm       = imm;
    c.pc        = pc;
    return c;
  endfunction

  function automatic s_trap_info_t mk_trap(input pc_t pc, input logic act);
    s_trap_info_t t;
    t.pc_addr = pc;
    t.active  = act;
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    fetch_start_i = 1'b0; fetch_start_addr_i = '0; jump_i = 1'b0; jump_addr_i = '0;
    fetch_valid_i = 1'b0; fetch_instr_i = '0; id_ready_i = 1'b1;
    step(); step();
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", fetch_ready_o); end
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", id_valid_o); end
    n_cmp++; if (id_ctrl_o !== '0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", id_ctrl_o); end
    n_cmp++; if (illegal_instr_o !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal_instr_o); end
    n_cmp++; if (trap_info_o !== '0) begin n_err++; $display("FAIL reset_trap got %h want 0", trap_info_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", fetch_ready_o); end
  endtask

  task automatic test_stream();
    s_id_ex_t exp;
    fetch_start_i = 1'b1; fetch_start_addr_i = 32'h8000_0000;
    #1;
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL start_flush_ready got %b want 0", fetch_ready_o); end
    step();
    fetch_start_i = 1'b0;
    id_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0050_0093; // ADDI x1,x0,5
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 32'h8000_0000);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL stream_addi got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    fetch_instr_i = 32'h1234_5137; // LUI x2,0x12345
    step();
    exp = mk(OpLui, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 32'h1234_5000, 32'h8000_0004);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL stream_lui got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    fetch_instr_i = 32'h0020_A223; // SW x2,4(x1)
    step();
    exp = mk(OpStore, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'd4, 32'h8000_0008);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL stream_sw got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    fetch_valid_i = 1'b0;
    step();
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", id_valid_o); end
  endtask

  task automatic test_stall();
    s_id_ex_t exp1;
    s_id_ex_t exp2;
    exp1 = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'd7, 32'h8000_000C);
    exp2 = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 32'd8, 32'h8000_0010);
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0070_0193; // ADDI x3,x0,7
    step();
    n_cmp++; if (id_ctrl_o !== exp1) begin n_err++; $display("FAIL stall_first got %h want %h", id_ctrl_o, exp1); end
    id_ready_i = 1'b0; fetch_instr_i = 32'h0080_0213; // ADDI x4,x0,8
    #1;
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready got %b want 0", fetch_ready_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (id_valid_o !== 1'b1 || id_ctrl_o !== exp1 || fetch_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got v=%b r=%b %h want v=1 r=0 %h", i, id_valid_o, fetch_ready_o, id_ctrl_o, exp1);
      end
    end
    id_ready_i = 1'b1;
    #1;
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_release got %b want 1", fetch_ready_o); end
    step();
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp2) begin n_err++; $display("FAIL stall_next got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp2); end
    fetch_valid_i = 1'b0;
    step();
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b want 0", id_valid_o); end
  endtask

  task automatic test_illegal();
    s_id_ex_t exp;
    jump_i = 1'b1; jump_addr_i = 32'h0000_0020;
    step();
    jump_i = 1'b0; id_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0000_0000;
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'h20);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL illegal0_nop got %h want %h", id_ctrl_o, exp); end
    n_cmp++; if (illegal_instr_o !== 1'b1) begin n_err++; $display("FAIL illegal0_pulse got %b want 1", illegal_instr_o); end
    n_cmp++; if (trap_info_o !== mk_trap(32'h20, 1'b1)) begin n_err++; $display("FAIL illegal0_trap got %h want %h", trap_info_o, mk_trap(32'h20, 1'b1)); end
    fetch_instr_i = 32'hFFFF_FFFF;
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'h24);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL illegal1_nop got %h want %h", id_ctrl_o, exp); end
    n_cmp++; if (illegal_instr_o !== 1'b1) begin n_err++; $display("FAIL illegal1_pulse got %b want 1", illegal_instr_o); end
    n_cmp++; if (trap_info_o !== mk_trap(32'h20, 1'b1)) begin n_err++; $display("FAIL illegal1_trap_sticky got %h want %h", trap_info_o, mk_trap(32'h20, 1'b1)); end
    fetch_valid_i = 1'b0;
    step();
    n_cmp++; if (illegal_instr_o !== 1'b0) begin n_err++; $display("FAIL illegal_pulse_end got %b want 0", illegal_instr_o); end
  endtask

  task automatic test_jump_flush();
    s_id_ex_t exp;
    id_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0010_0293; // ADDI x5,x0,1
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd1, 32'h28);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL jump_held got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    jump_i = 1'b1; jump_addr_i = 32'h0000_0103; fetch_instr_i = 32'h0020_0313; // ADDI x6,x0,2
    #1;
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL jump_flush_ready got %b want 0", fetch_ready_o); end
    step();
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL jump_drop got %b want 0", id_valid_o); end
    n_cmp++; if (trap_info_o !== '0) begin n_err++; $display("FAIL jump_trap_clear got %h want 0", trap_info_o); end
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL jump_held_high_ready got %b want 1", fetch_ready_o); end
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 32'd2, 32'h100);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL jump_target got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    id_ready_i = 1'b1; fetch_instr_i = 32'h0030_0393; // ADDI x7,x0,3
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 32'd3, 32'h104);
    n_cmp++; if (id_valid_o !== 1'b1 || id_ctrl_o !== exp) begin n_err++; $display("FAIL jump_pop_accept got v=%b %h want v=1 %h", id_valid_o, id_ctrl_o, exp); end
    jump_i = 1'b0; fetch_valid_i = 1'b0;
    step();
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++; $display("FAIL jump_drain got %b want 0", id_valid_o); end
  endtask

  task automatic test_imm();
    s_id_ex_t exp;
    id_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_instr_i = 32'h8000_0063; // BEQ x0,x0,-4096
    step();
    exp = mk(OpBranch, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_F000, 32'h108);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL imm_beq got %h want %h", id_ctrl_o, exp); end
    fetch_instr_i = 32'h7FFF_F0EF; // JAL x1,+1048574
    step();
    exp = mk(OpJal, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h000F_FFFE, 32'h10C);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL imm_jal got %h want %h", id_ctrl_o, exp); end
    fetch_instr_i = 32'h0FF0_000F; // FENCE
    step();
    exp = mk(OpFence, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'h110);
    n_cmp++; if (id_ctrl_o !== exp || illegal_instr_o !== 1'b0) begin n_err++; $display("FAIL fence_nop got %h ill=%b want %h ill=0", id_ctrl_o, illegal_instr_o, exp); end
    fetch_instr_i = 32'h4020_9033; // funct7 0x20 with SLL: illegal
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'h114);
    n_cmp++; if (id_ctrl_o !== exp || illegal_instr_o !== 1'b1) begin n_err++; $display("FAIL op_bad_f7 got %h ill=%b want %h ill=1", id_ctrl_o, illegal_instr_o, exp); end
    fetch_instr_i = 32'h4020_81B3; // SUB x3,x1,x2
    step();
    exp = mk(OpReg, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'd0, 32'h118);
    n_cmp++; if (id_ctrl_o !== exp || illegal_instr_o !== 1'b0) begin n_err++; $display("FAIL op_sub got %h ill=%b want %h ill=0", id_ctrl_o, illegal_instr_o, exp); end
    n_cmp++; if (trap_info_o !== mk_trap(32'h114, 1'b1)) begin n_err++; $display("FAIL op_trap got %h want %h", trap_info_o, mk_trap(32'h114, 1'b1)); end
    fetch_valid_i = 1'b0;
    step();
  endtask

  task automatic test_pc_wrap();
    s_id_ex_t exp;
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    step();
    n_cmp++; if (trap_info_o !== '0) begin n_err++; $display("FAIL wrap_trap_clear got %h want 0", trap_info_o); end
    jump_i = 1'b0; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0070_0193;
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'd7, 32'hFFFF_FFFC);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL wrap_last got %h want %h", id_ctrl_o, exp); end
    fetch_instr_i = 32'h0080_0213;
    step();
    exp = mk(OpImm, 3'd0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 32'd8, 32'h0000_0000);
    n_cmp++; if (id_ctrl_o !== exp) begin n_err++; $display("FAIL wrap_zero got %h want %h", id_ctrl_o, exp); end
    fetch_valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    id_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_instr_i = 32'h0010_0293;
    step();
    n_cmp++; if (id_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_pre got %b want 1", id_valid_o); end
    rst = 1'b1; fetch_valid_i = 1'b0;
    step();
    n_cmp++; if (id_valid_o !== 1'b0 || id_ctrl_o !== '0) begin n_err++; $display("FAIL mid_reset got v=%b %h want v=0 0", id_valid_o, id_ctrl_o); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_illegal();
    test_jump_flush();
    test_imm();
    test_pc_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Decode stage of the core, directly downstream of the fetch stage. Accepts raw 32-bit RV32I instructions over the fetch valid/ready handshake, tracks the PC of each instruction, decodes it into a control struct with generated immediate, and holds it in a single output register for the execute stage. Flushes on a start or jump request and flags illegal instructions as a trap.

## Interface
- `SUPPORT_FENCE`, default 1: 1 = FENCE/FENCE.I decode as NOP; 0 = illegal.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_start_i`  in  1  core start; same signal fetch sees.
- `fetch_start_addr_i`  in  32 (`pc_t`)  boot PC.
- `jump_i`  in  1  jump/branch-taken request from EXEC; same signal as fetch's request.
- `jump_addr_i`  in  32 (`pc_t`)  jump target.
- `fetch_valid_i`  in  1  fetch has an instruction.
- `fetch_ready_o`  out  1  decode accepts this cycle.
- `fetch_instr_i`  in  32 (`instr_raw_t`)  raw instruction.
- `id_valid_o`  out  1  decoded entry valid.
- `id_ready_i`  in  1  EXEC accepts.
- `id_ctrl_o`  out  `s_id_ex_t`  decoded control (op class, funct3, funct7 bit, rs1, rs2, rd, rd_we, imm, pc).
- `illegal_instr_o`  out  1  pulse: illegal instruction entered output register.
- `trap_info_o`  out  `s_trap_info_t`  sticky trap: pc_addr, active.

## Operation
- Flush event: `flush = start_trig | jump_trig`. `start_trig` = rising edge of `fetch_start_i` (registered copy); `jump_trig` = rising edge of `jump_i`. Edge detection identical to fetch so both stages flush in the same cycle.
- PC: `pc_ff` loads `fetch_start_addr_i` on `start_trig`, `{jump_addr_i[31:2],2'b00}` on `jump_trig` (start wins if both). Otherwise increments by 4 on every accepted instruction (`fetch_valid_i & fetch_ready_o`). Wraps modulo 2^32.
- Handshake: `fetch_ready_o = ~flush & (~id_valid_ff | id_ready_i)`. Accept writes decoded entry (with current `pc_ff`) into output register and sets `id_valid_ff`. Output pop (`id_valid_o & id_ready_i`) without accept clears `id_valid_ff`.
- Flush clears `id_valid_ff` in the same cycle; the held entry is dropped, no accept occurs.
- Decode: opcode classes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM (ECALL/EBREAK/MRET/CSR*). Immediate sign-extended per I/S/B/U/J format; B/J LSB forced 0. `rd_we` = 0 for BRANCH, STORE, FENCE, ECALL/EBREAK/MRET, or rd == 0.
- Illegal: `instr[1:0] != 2'b11`, unknown opcode, OP funct7 not in {0x00, 0x20}, funct7 0x20 with funct3 not ADD/SRA, OP_IMM shifts with bad funct7, LOAD funct3 in {3,6,7}, STORE funct3 > 2, BRANCH funct3 in {2,3}, FENCE when `SUPPORT_FENCE` = 0. An illegal instruction is entered as NOP (ADDI x0,x0,0, `rd_we` = 0). `illegal_instr_o` pulses for one cycle. If `trap_ff.active` = 0, latch `trap_ff` = {pc of that instr, active = 1}; a first trap is never overwritten.
- `trap_ff` clears to 0 on flush (flush wins over a same-cycle illegal).

## Timing
- Reset: `fetch_ready_o` = 0 (flush/valid regs cleared; becomes 1 next cycle), `id_valid_o` = 0, `id_ctrl_o` = 0, `illegal_instr_o` = 0, `trap_info_o` = 0, `pc_ff` = 0. Reset mid-operation discards the held entry.
- Latency: 1 cycle from accept to `id_valid_o`. Full throughput when `id_ready_i` = 1.
- `id_ctrl_o` stable while `id_valid_o & ~id_ready_i`.
- Simultaneous pop and accept: register replaced, `id_valid_o` stays 1.
- Flush with `fetch_valid_i` = 1: instruction not accepted, PC not incremented.
- `jump_i` held high for many cycles causes exactly one flush.

## Structure
- `utils_pkg`: `s_id_ex_t`, `op_class_t`, `imm_fmt_t`, RV32I opcode constants, NOP encoding.
- Single module; decode logic is a `utils_pkg` function `decode_rv32i`. No sub-module.

## Test plan
- Start at 0x8000_0000, stream ADDI x1,x0,5 / LUI x2,0x12345 / SW x2,4(x1) with `id_ready_i` = 1 -> pc 0x8000_0000/04/08, imm 5 / 0x12345000 / 4, SW `rd_we` = 0, one per cycle.
- `id_ready_i` low 3 cycles mid-stream -> `fetch_ready_o` = 0, `id_ctrl_o` unchanged, no instruction lost or duplicated.
- Jump edge to 0x100 while entry held -> `id_valid_o` = 0 next cycle, next accepted instr pc = 0x100, `trap_info_o` cleared.
- Illegal 0x0000_0000 at pc 0x20 then 0xFFFF_FFFF -> entries are NOP, `illegal_instr_o` pulses twice, `trap_info_o` = {0x20, 1}.
- BEQ imm -4096 and JAL imm +1048574 -> exact sign-extended immediates, LSB 0.
- PC 0xFFFF_FFFC accept -> next pc 0x0000_0000.
